hazard_forward_unit: RTL and testbench

Parametrised next-generation forwarding and hazard controller for the 5-stage pipeline (F/D, D/X, X/M, M/W).
- Forwards operands into the DX-stage ALU inputs and the XM-stage store-data path.
- Detects load-use hazards and stalls F/D for one cycle.
- Holds a one-entry scoreboard for the multi-cycle mult/div unit: stalls dependent instructions until the result is ready, then requests its writeback.
- Keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/hazard_forward_unit.sv | 115 +++++++++++
 tb/tb_hazard_forward_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard controller for the 5-stage pipeline: operand forwarding,
// load-use stalls, a one-entry mult/div scoreboard and a saturating stall counter.
module hazard_forward_unit #(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [REG_AW-1:0] fd_rs,
    input  logic [REG_AW-1:0] fd_rt,
    input  logic              fd_is_md,
    input  logic [REG_AW-1:0] dx_rs,
    input  logic [REG_AW-1:0] dx_rt,
    input  logic [REG_AW-1:0] dx_rd,
    input  logic              dx_is_lw,
    input  logic [REG_AW-1:0] xm_rd,
    input  logic [REG_AW-1:0] xm_rt,
    input  logic              xm_we,
    input  logic              xm_is_sw,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic              mw_we,
    input  logic              md_start,
    output logic [1:0]        mux_A_sel,
    output logic [1:0]        mux_B_sel,
    output logic              mux_D_sel,
    output logic              stall,
    output logic              md_busy,
    output logic              md_wb_req,
    output logic [REG_AW-1:0] md_wb_rd,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_XM = 2'b00;
    localparam logic [1:0] SEL_MW = 2'b01;
    localparam logic [1:0] SEL_RF = 2'b10;

    // BUSY lasts MD_LATENCY-1 cycles, so cnt only has to reach MD_LATENCY-1.
    localparam int MD_CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MD_CW-1:0] MD_LAST = MD_CW'(MD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } md_state_t;

    md_state_t         state, state_d;
    logic [MD_CW-1:0]  cnt, cnt_d, cnt_inc;
    logic [REG_AW-1:0] md_rd_d;
    logic              load_use_hazard;
    logic              md_hazard;
    logic              md_window;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (src != '0 && xm_we && !xm_is_sw && xm_rd == src) return SEL_XM;
        if (src != '0 && mw_we && mw_rd == src)              return SEL_MW;
        return SEL_RF;
    endfunction

    assign mux_A_sel = fwd_sel(dx_rs);
    assign mux_B_sel = fwd_sel(dx_rt);
    assign mux_D_sel = xm_is_sw && mw_we && (xm_rt == mw_rd) && (xm_rt != '0);

    assign load_use_hazard = dx_is_lw && (dx_rd != '0) &&
                             ((dx_rd == fd_rs) || (dx_rd == fd_rt));

    // The DONE cycle still stalls, unless D/X is issuing a new mult/div that cycle.
    assign md_window = (state == BUSY) || (state == DONE && !md_start);
    assign md_hazard = md_window &&
                       (fd_is_md || (fd_rs == md_wb_rd) || (fd_rt == md_wb_rd));

    assign stall     = load_use_hazard || md_hazard;
    assign md_busy   = (state != IDLE);
    assign md_wb_req = (state == DONE);
    assign cnt_inc   = cnt + 1'b1;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d = state;
        cnt_d   = cnt;
        md_rd_d = md_wb_rd;
        unique case (state)
            IDLE: begin
                if (md_start && dx_rd != '0) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    md_rd_d = dx_rd;
                end
            end
            BUSY: begin
                cnt_d = cnt_inc;
                if (cnt_inc == MD_LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            md_wb_rd    <= '0;
            stall_count <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            md_wb_rd <= md_rd_d;
            if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed test-plan steps followed by
// randomized cycles compared against a cycle-window reference model.
module tb_hazard_forward_unit;

    localparam int AW  = 5;
    localparam int L   = 4;
    localparam int CW  = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          resetn;
    logic [AW-1:0] fd_rs, fd_rt, dx_rs, dx_rt, dx_rd, xm_rd, xm_rt, mw_rd;
    logic          fd_is_md, dx_is_lw, xm_we, xm_is_sw, mw_we, md_start;
    logic [1:0]    mux_A_sel, mux_B_sel;
    logic          mux_D_sel, stall, md_busy, md_wb_req;
    logic [AW-1:0] md_wb_rd;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Reference model: an accepted mult/div occupies cycles (issue, issue+L].
    int            cyc = 0;
    int            md_issue = 0;
    bit            md_valid = 0;
    logic [AW-1:0] md_rd_m = '0;
    int            scount = 0;

    hazard_forward_unit #(.REG_AW(AW), .MD_LATENCY(L), .CNT_W(CW)) dut (
        .clock(clock), .resetn(resetn),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_is_md(fd_is_md),
        .dx_rs(dx_rs), .dx_rt(dx_rt), .dx_rd(dx_rd), .dx_is_lw(dx_is_lw),
        .xm_rd(xm_rd), .xm_rt(xm_rt), .xm_we(xm_we), .xm_is_sw(xm_is_sw),
        .mw_rd(mw_rd), .mw_we(mw_we), .md_start(md_start),
        .mux_A_sel(mux_A_sel), .mux_B_sel(mux_B_sel), .mux_D_sel(mux_D_sel),
        .stall(stall), .md_busy(md_busy), .md_wb_req(md_wb_req),
        .md_wb_rd(md_wb_rd), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
        if (src != 0 && xm_we && !xm_is_sw && xm_rd == src) return 2'b00;
        if (src != 0 && mw_we && mw_rd == src)              return 2'b01;
        return 2'b10;
    endfunction

    function automatic bit m_done();
        return md_valid && (cyc == md_issue + L);
    endfunction

    function automatic bit m_stall();
        bit lu, mh;
        lu = dx_is_lw && dx_rd != 0 && (dx_rd == fd_rs || dx_rd == fd_rt);
        mh = md_valid && !(m_done() && md_start) &&
             (fd_is_md || fd_rs == md_rd_m || fd_rt == md_rd_m);
        return lu || mh;
    endfunction

    task automatic clear_inputs();
        {fd_rs, fd_rt, dx_rs, dx_rt, dx_rd, xm_rd, xm_rt, mw_rd} = '0;
        {fd_is_md, dx_is_lw, xm_we, xm_is_sw, mw_we, md_start} = '0;
    endtask

    // Mid-cycle comparison of every output against the model.
    task automatic settle();
        #4;
        check("mux_A_sel", mux_A_sel, m_fwd(dx_rs));
        check("mux_B_sel", mux_B_sel, m_fwd(dx_rt));
        check("mux_D_sel", mux_D_sel, xm_is_sw && mw_we && xm_rt == mw_rd && xm_rt != 0);
        check("stall", stall, m_stall());
        check("md_busy", md_busy, md_valid);
        check("md_wb_req", md_wb_req, m_done());
        check("md_wb_rd", md_wb_rd, md_rd_m);
        check("stall_count", stall_count, scount);
    endtask

    // Advance one clock; the model updates from this cycle's inputs.
    task automatic tick();
        bit s, d;
        s = m_stall();
        d = m_done();
        @(posedge clock);
        if (!resetn) begin
            md_valid = 0;
            md_rd_m  = '0;
            scount   = 0;
        end else begin
            if (s && scount < CNT_MAX) scount++;
            if (d) md_valid = 0;
            else if (!md_valid && md_start && dx_rd != 0) begin
                md_valid = 1;
                md_issue = cyc;
                md_rd_m  = dx_rd;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        settle();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        @(negedge clock);
        tick();
        resetn = 1'b1;

        // Reset state
        settle();
        check("rst_busy", md_busy, 0);
        check("rst_wb_req", md_wb_req, 0);
        check("rst_count", stall_count, 0);
        check("rst_wb_rd", md_wb_rd, 0);

        // Forwarding priority
        dx_rs = 3; xm_rd = 3; xm_we = 1; mw_rd = 3; mw_we = 1;
        settle(); check("fwd_xm", mux_A_sel, 2'b00);
        xm_we = 0;
        settle(); check("fwd_mw", mux_A_sel, 2'b01);
        dx_rs = 0;
        settle(); check("fwd_r0", mux_A_sel, 2'b10);
        clear_inputs();

        // Store data forwarding
        xm_is_sw = 1; xm_rt = 7; mw_rd = 7; mw_we = 1;
        settle(); check("sd_fwd", mux_D_sel, 1);
        xm_rt = 0; mw_rd = 0;
        settle(); check("sd_r0", mux_D_sel, 0);
        clear_inputs();

        // Load-use: one stall cycle, then the load forwards from MW
        do_reset();
        dx_is_lw = 1; dx_rd = 5; fd_rt = 5;
        settle(); check("lu_stall", stall, 1);
        tick();
        clear_inputs();
        dx_rt = 5; mw_rd = 5; mw_we = 1;
        settle();
        check("lu_release", stall, 0);
        check("lu_fwd", mux_B_sel, 2'b01);
        check("lu_count", stall_count, 1);
        tick();

        // Mult/div dependency with latency 4
        do_reset();
        md_start = 1; dx_rd = 9; fd_rs = 9;
        settle(); check("md_c0_stall", stall, 0);
        tick();
        md_start = 0; dx_rd = 0;
        for (int k = 1; k <= L; k++) begin
            settle();
            check($sformatf("md_c%0d_stall", k), stall, 1);
            check($sformatf("md_c%0d_wbreq", k), md_wb_req, k == L);
            check($sformatf("md_c%0d_busy", k), md_busy, 1);
            check($sformatf("md_c%0d_wbrd", k), md_wb_rd, 9);
            tick();
        end
        settle();
        check("md_c5_busy", md_busy, 0);
        check("md_c5_stall", stall, 0);
        check("md_count", stall_count, L);
        tick();

        // Structural hazard, then reset aborts the operation
        do_reset();
        md_start = 1; dx_rd = 12;
        settle(); tick();
        md_start = 0; dx_rd = 0; fd_is_md = 1;
        settle(); check("struct_stall", stall, 1);
        tick();
        resetn = 1'b0;
        settle(); tick();
        resetn = 1'b1;
        for (int k = 0; k < 2 * L; k++) begin
            settle();
            check("abort_wbreq", md_wb_req, 0);
            check("abort_busy", md_busy, 0);
            tick();
        end
        clear_inputs();

        // Saturation of the 3-bit stall counter
        do_reset();
        dx_is_lw = 1; dx_rd = 5; fd_rs = 5;
        for (int k = 1; k <= 10; k++) begin
            settle(); tick();
            check("sat_count", stall_count, (k < CNT_MAX) ? k : CNT_MAX);
        end
        clear_inputs();

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            resetn   = ($urandom_range(0, 49) != 0);
            fd_rs    = AW'($urandom_range(0, 3));
            fd_rt    = AW'($urandom_range(0, 3));
            dx_rs    = AW'($urandom_range(0, 3));
            dx_rt    = AW'($urandom_range(0, 3));
            dx_rd    = AW'($urandom_range(0, 3));
            xm_rd    = AW'($urandom_range(0, 3));
            xm_rt    = AW'($urandom_range(0, 3));
            mw_rd    = AW'($urandom_range(0, 3));
            fd_is_md = ($urandom_range(0, 7) == 0);
            dx_is_lw = ($urandom_range(0, 3) == 0);
            xm_we    = $urandom_range(0, 1);
            xm_is_sw = $urandom_range(0, 1);
            mw_we    = $urandom_range(0, 1);
            md_start = ($urandom_range(0, 5) == 0);
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
